// File: rtl/parity_pkg.sv
// Shared types and constants for the 4x4 row/column parity checker.
// Holds the FSM state encoding, word geometry, LFSR taps and parity helpers.
package parity_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned WORD_W = 16;

    // Taps q[3] and q[2]: x^4 + x^3 + 1, maximal length (period 15, never 0)
    localparam logic [3:0] LFSR_TAPS = 4'b1100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_INJECT,
        S_CHECK,
        S_CORRECT,
        S_DONE
    } state_t;

    function automatic logic [ROWS-1:0] row_parity(input logic [WORD_W-1:0] w);
        logic [ROWS-1:0] p;
        p = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            p[r] = ^w[r*COLS +: COLS];
        end
        return p;
    endfunction

    function automatic logic [COLS-1:0] col_parity(input logic [WORD_W-1:0] w);
        logic [COLS-1:0] p;
        p = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                p[c] = p[c] ^ w[r*COLS + c];
            end
        end
        return p;
    endfunction

    function automatic logic [3:0] lfsr_next(input logic [3:0] q);
        return {q[2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/parity_syndrome.sv
// Combinational syndrome: compares the working word's row/column parities
// against the reference and encodes a single-bit error position.
module parity_syndrome
    import parity_pkg::*;
(
    input  logic [WORD_W-1:0] num,
    input  logic [ROWS-1:0]   ref_row,
    input  logic [COLS-1:0]   ref_col,
    output logic [ROWS-1:0]   row_mis,
    output logic [COLS-1:0]   col_mis,
    output logic [3:0]        err_pos,
    output logic              single,
    output logic              clean
);

    logic [1:0] w_row_idx;
    logic [1:0] w_col_idx;

    assign row_mis = row_parity(num) ^ ref_row;
    assign col_mis = col_parity(num) ^ ref_col;

    // Index is only meaningful when exactly one bit is set in each vector
    always_comb begin
        w_row_idx = '0;
        w_col_idx = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (row_mis[r]) w_row_idx = 2'(r);
        end
        for (int unsigned c = 0; c < COLS; c++) begin
            if (col_mis[c]) w_col_idx = 2'(c);
        end
    end

    assign err_pos = {w_row_idx, w_col_idx};
    assign single  = $onehot(row_mis) && $onehot(col_mis);
    assign clean   = ~|{row_mis, col_mis};

endmodule

// File: rtl/parity_check_ctrl.sv
// Parity-protected word with LFSR-driven fault injection and single-bit
// correction, sequenced by a small request-driven FSM.
module parity_check_ctrl
    import parity_pkg::*;
#(
    parameter logic [3:0] LFSR_SEED = 4'b0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] sw,
    input  logic              start,
    input  logic              inject,
    input  logic              correct,
    output logic [WORD_W-1:0] num,
    output logic [3:0]        inj_pos,
    output logic [3:0]        err_pos,
    output logic              err_valid,
    output logic              uncorrectable,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    state_t            w_next;
    logic [WORD_W-1:0] r_num;
    logic [3:0]        r_inj_pos;
    logic [3:0]        r_err_pos;
    logic              r_err_valid;
    logic              r_uncorr;
    logic [ROWS-1:0]   r_ref_row;
    logic [COLS-1:0]   r_ref_col;
    logic [3:0]        r_lfsr;
    logic [3:0]        w_lfsr_pos;
    logic [ROWS-1:0]   w_row_mis;
    logic [COLS-1:0]   w_col_mis;
    logic [3:0]        w_err_pos;
    logic              w_single;
    logic              w_clean;

    parity_syndrome u_syndrome (
        .num     (r_num),
        .ref_row (r_ref_row),
        .ref_col (r_ref_col),
        .row_mis (w_row_mis),
        .col_mis (w_col_mis),
        .err_pos (w_err_pos),
        .single  (w_single),
        .clean   (w_clean)
    );

    assign w_lfsr_pos = r_lfsr - 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE:    if (start) w_next = S_LOAD;
            S_LOAD:    begin busy = 1'b1; w_next = S_DONE; end
            S_READY: begin
                if (start)        w_next = S_LOAD;
                else if (correct) w_next = S_CHECK;
                else if (inject)  w_next = S_INJECT;
            end
            S_INJECT:  begin busy = 1'b1; w_next = S_DONE; end
            S_CHECK:   begin busy = 1'b1; w_next = w_single ? S_CORRECT : S_DONE; end
            S_CORRECT: begin busy = 1'b1; w_next = S_DONE; end
            S_DONE:    begin done = 1'b1; w_next = S_READY; end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num       <= '0;
            r_inj_pos   <= '0;
            r_err_pos   <= '0;
            r_err_valid <= 1'b0;
            r_uncorr    <= 1'b0;
            r_ref_row   <= '0;
            r_ref_col   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_num       <= sw;
                    r_ref_row   <= row_parity(sw);
                    r_ref_col   <= col_parity(sw);
                    r_err_valid <= 1'b0;
                    r_uncorr    <= 1'b0;
                end
                S_INJECT: begin
                    r_inj_pos <= w_lfsr_pos;
                    r_num     <= r_num ^ (WORD_W'(1) << w_lfsr_pos);
                end
                S_CHECK: begin
                    r_err_valid <= w_single;
                    r_uncorr    <= ~w_single & ~w_clean;
                    if (w_single) r_err_pos <= w_err_pos;
                end
                S_CORRECT: r_num <= r_num ^ (WORD_W'(1) << r_err_pos);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= lfsr_next(r_lfsr);
    end

    // Syndrome self-consistency: clean must mean no row and no column mismatch
    always_comb begin
        assert (w_clean == ~|{w_row_mis, w_col_mis});
    end

    assign num           = r_num;
    assign inj_pos       = r_inj_pos;
    assign err_pos       = r_err_pos;
    assign err_valid     = r_err_valid;
    assign uncorrectable = r_uncorr;

endmodule

// File: tb/tb_parity_check_ctrl.sv
// Directed, table-driven bench for parity_check_ctrl with an independent
// LFSR model to predict injection positions.
module tb_parity_check_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] sw;
    logic        start;
    logic        inject;
    logic        correct;
    logic [15:0] num;
    logic [3:0]  inj_pos;
    logic [3:0]  err_pos;
    logic        err_valid;
    logic        uncorrectable;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] m_lfsr;

    parity_check_ctrl #(.LFSR_SEED(4'b0001)) dut (
        .clk           (clk),
        .rst           (rst),
        .sw            (sw),
        .start         (start),
        .inject        (inject),
        .correct       (correct),
        .num           (num),
        .inj_pos       (inj_pos),
        .err_pos       (err_pos),
        .err_valid     (err_valid),
        .uncorrectable (uncorrectable),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^4 + x^3 + 1, seeded with 1
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 4'b0001;
        else     m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
    end

    typedef struct {
        logic [15:0] sw;
        int          n_inj;
        int          exp_lat;
        logic        exp_ev;
        logic        exp_unc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request pulse sampled in READY; lat = edges until done seen,
    // lf = LFSR value the DUT uses on the following edge.
    task automatic do_op(input logic s, input logic i, input logic c,
                         output int lat, output logic [3:0] lf);
        @(negedge clk);
        start = s; inject = i; correct = c;
        @(posedge clk); #1;
        start = 1'b0; inject = 1'b0; correct = 1'b0;
        lf  = m_lfsr;
        lat = 1;
        while (!done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = 99;
        @(posedge clk); #1;
        chk("done_pulse", {31'b0, done}, 32'd0);
    endtask

    int          lat;
    logic [3:0]  lf;
    logic [3:0]  p, p1, p2;
    logic [15:0] exp_num;

    initial begin
        vecs[0] = '{16'h0000, 0, 2, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 1, 3, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 2, 2, 1'b0, 1'b1};
        vecs[3] = '{16'h8001, 1, 3, 1'b1, 1'b0};
        vecs[4] = '{16'h5A5A, 0, 2, 1'b0, 1'b0};
        vecs[5] = '{16'hC0DE, 2, 2, 1'b0, 1'b1};

        rst = 1'b1; sw = '0; start = 1'b0; inject = 1'b0; correct = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_num",   32'(num), 32'd0);
        chk("rst_inj",   32'(inj_pos), 32'd0);
        chk("rst_epos",  32'(err_pos), 32'd0);
        chk("rst_ev",    32'(err_valid), 32'd0);
        chk("rst_unc",   32'(uncorrectable), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        @(negedge clk) rst = 1'b0;

        // inject/correct ignored in IDLE
        @(negedge clk) begin inject = 1'b1; correct = 1'b1; end
        @(negedge clk) begin inject = 1'b0; correct = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        chk("idle_num",  32'(num), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_inj",  32'(inj_pos), 32'd0);

        sw = 16'hA5C3;
        do_op(1'b1, 1'b0, 1'b0, lat, lf);
        chk("load_lat", 32'(lat), 32'd2);
        chk("load_num", 32'(num), 32'hA5C3);
        chk("load_ev",  32'(err_valid), 32'd0);

        do_op(1'b0, 1'b1, 1'b0, lat, lf);
        p = lf - 4'd1;
        chk("inj_lat", 32'(lat), 32'd2);
        chk("inj_pos", 32'(inj_pos), 32'(p));
        chk("inj_num", 32'(num), 32'(16'hA5C3 ^ (16'h1 << p)));

        do_op(1'b0, 1'b0, 1'b1, lat, lf);
        chk("cor_lat",  32'(lat), 32'd3);
        chk("cor_epos", 32'(err_pos), 32'(p));
        chk("cor_ev",   32'(err_valid), 32'd1);
        chk("cor_unc",  32'(uncorrectable), 32'd0);
        chk("cor_num",  32'(num), 32'hA5C3);

        repeat (4) @(posedge clk);
        #1;
        chk("hold_ev",   32'(err_valid), 32'd1);
        chk("hold_epos", 32'(err_pos), 32'(p));

        do_op(1'b0, 1'b0, 1'b1, lat, lf);
        chk("clean_lat", 32'(lat), 32'd2);
        chk("clean_ev",  32'(err_valid), 32'd0);
        chk("clean_unc", 32'(uncorrectable), 32'd0);
        chk("clean_num", 32'(num), 32'hA5C3);

        do_op(1'b0, 1'b1, 1'b0, lat, lf);
        p1 = lf - 4'd1;
        do_op(1'b0, 1'b1, 1'b0, lat, lf);
        p2 = lf - 4'd1;
        chk("dbl_distinct", 32'(p1 != p2), 32'd1);
        exp_num = 16'hA5C3 ^ (16'h1 << p1) ^ (16'h1 << p2);
        do_op(1'b0, 1'b0, 1'b1, lat, lf);
        chk("dbl_lat", 32'(lat), 32'd2);
        chk("dbl_unc", 32'(uncorrectable), 32'd1);
        chk("dbl_ev",  32'(err_valid), 32'd0);
        chk("dbl_num", 32'(num), 32'(exp_num));
        do_op(1'b0, 1'b0, 1'b1, lat, lf);
        chk("dbl_num2", 32'(num), 32'(exp_num));
        chk("dbl_unc2", 32'(uncorrectable), 32'd1);

        for (int i = 0; i < 6; i++) begin
            sw = vecs[i].sw;
            do_op(1'b1, 1'b0, 1'b0, lat, lf);
            chk("tbl_load_num", 32'(num), 32'(vecs[i].sw));
            chk("tbl_load_unc", 32'(uncorrectable), 32'd0);
            exp_num = vecs[i].sw;
            for (int k = 0; k < vecs[i].n_inj; k++) begin
                do_op(1'b0, 1'b1, 1'b0, lat, lf);
                exp_num = exp_num ^ (16'h1 << (lf - 4'd1));
            end
            if (vecs[i].n_inj == 1) exp_num = vecs[i].sw;
            do_op(1'b0, 1'b0, 1'b1, lat, lf);
            chk("tbl_lat", 32'(lat), 32'(vecs[i].exp_lat));
            chk("tbl_ev",  32'(err_valid), 32'(vecs[i].exp_ev));
            chk("tbl_unc", 32'(uncorrectable), 32'(vecs[i].exp_unc));
            chk("tbl_num", 32'(num), 32'(exp_num));
        end

        // requests arriving in LOAD and DONE are dropped
        sw = 16'h0F0F;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; inject = 1'b1;
        @(posedge clk); #1;
        inject = 1'b0; correct = 1'b1;
        @(posedge clk); #1;
        correct = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("drop_num",  32'(num), 32'h0F0F);
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_ev",   32'(err_valid), 32'd0);

        sw = 16'h3C96;
        do_op(1'b1, 1'b1, 1'b1, lat, lf);
        chk("prio_lat", 32'(lat), 32'd2);
        chk("prio_num", 32'(num), 32'h3C96);
        chk("prio_ev",  32'(err_valid), 32'd0);

        // reset during CHECK
        @(negedge clk) correct = 1'b1;
        @(posedge clk); #1;
        correct = 1'b0;
        chk("chk_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_num",  32'(num), 32'd0);
        chk("ar_inj",  32'(inj_pos), 32'd0);
        chk("ar_epos", 32'(err_pos), 32'd0);
        chk("ar_ev",   32'(err_valid), 32'd0);
        chk("ar_unc",  32'(uncorrectable), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done), 32'd0);

        @(negedge clk) begin rst = 1'b0; start = 1'b1; sw = 16'h7E81; end
        @(posedge clk); #1;
        start = 1'b0;
        chk("first_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("first_done", 32'(done), 32'd1);
        chk("first_num",  32'(num), 32'h7E81);

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("lfsr_val", 32'(dut.r_lfsr), 32'(m_lfsr));
            chk("lfsr_nz",  32'(dut.r_lfsr != 4'd0), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
